// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared opcodes, state encoding and mux-select encodings for the
//               RV64 multicycle control path.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LD_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_RTYPE = 2'b10;
    localparam logic [1:0] c_ALU_ITYPE = 2'b11;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR = 2'b01;
    localparam logic [1:0] c_SRCB_IMM  = 2'b10;

    // Dispatch out of DECODE; unsupported opcodes go straight to TRAP.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: decode_next = S_MEM_ADDR;
            OP_IMM:            decode_next = S_EXEC_I;
            OP_REG:            decode_next = S_EXEC_R;
            OP_BRANCH:         decode_next = S_BRANCH;
            default:           decode_next = S_TRAP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Memory stall counter; flags when the stall count reaches the
//               configured limit. A limit of 0 disables the flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int                 c_CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT   = c_CNT_W'(MEM_TIMEOUT);
    localparam logic               c_ENABLED = (MEM_TIMEOUT > 0);

    logic [c_CNT_W-1:0] r_count;

    // Saturates at the limit so the count never wraps back below it.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = c_ENABLED && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM of the RV64 multicycle core (ld, sd, addi,
//               beq, R-type) with memory-ready watchdog and sticky trap.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_src,
    output logic       instr_retired,
    output logic       trap,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   w_waiting;
    logic   w_stall;
    logic   w_timeout;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_stall   = w_waiting && !mem_ready;

    // Any cycle that is not a stall clears the count, which covers every entry
    // into a waiting state as well as leaving it.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (!w_stall),
        .i_en      (w_stall),
        .o_timeout (w_timeout)
    );

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_SRCB_RS2;
        alu_op        = c_ALU_ADD;
        pc_src        = 1'b0;
        instr_retired = 1'b0;
        trap          = 1'b0;
        w_next        = r_state;

        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = c_SRCB_FOUR;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = c_SRCB_IMM;
                w_next    = decode_next(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                w_next    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_next = S_LD_WB;
            end
            S_LD_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_RS2;
                alu_op    = c_ALU_RTYPE;
                w_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_op    = c_ALU_ITYPE;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = c_SRCB_RS2;
                alu_op        = c_ALU_SUB;
                instr_retired = 1'b1;
                if (alu_zero) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap   = 1'b1;
                w_next = S_TRAP;
            end
        endcase

        // mem_ready in the compare cycle wins because w_stall is then low.
        if (w_stall && w_timeout) w_next = S_TRAP;

        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            i_or_d        = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = c_SRCB_RS2;
            alu_op        = c_ALU_ADD;
            pc_src        = 1'b0;
            instr_retired = 1'b0;
            trap          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = reset ? S_FETCH : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl (watchdog
//               limit reduced to 4 stall cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic       mem_to_reg, alu_src_a, pc_src, instr_retired, trap;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    int nvec = 0;
    int nerr = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .instr_retired (instr_retired),
        .trap          (trap),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; inputs for that cycle are driven afterwards.
    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go();
            nvec++;
            if ({state, mem_read, ir_write, trap} !== 7'b0) begin
                nerr++;
                $display("FAIL reset_hold[%0d]: got state/rd/ir/trap %b want 0000000", k,
                         {state, mem_read, ir_write, trap});
            end
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (state !== S_FETCH || mem_read !== 1'b1 || i_or_d !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: got state %0d mem_read %b i_or_d %b want 0 1 0",
                     state, mem_read, i_or_d);
        end
    endtask

    task automatic test_rtype();
        state_t st[4];
        st = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB};
        opcode = OP_REG;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) begin
                mem_ready = 1'b1;
                #1;
                nvec++;
                if (state !== st[k] || reg_write !== (k == 3) || instr_retired !== (k == 3)) begin
                    nerr++;
                    $display("FAIL rtype[%0d.%0d]: got state %0d wr %b ret %b want %0d %b %b",
                             n, k, state, reg_write, instr_retired, st[k], k == 3, k == 3);
                end
                if (k == 0) begin
                    nvec++;
                    if ({ir_write, pc_write, alu_src_b, alu_op, pc_src} !== 7'b1_1_01_00_0) begin
                        nerr++;
                        $display("FAIL rtype_fetch: got %b want 1101000",
                                 {ir_write, pc_write, alu_src_b, alu_op, pc_src});
                    end
                end
                if (k == 2) begin
                    nvec++;
                    if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_10) begin
                        nerr++;
                        $display("FAIL rtype_exec: got %b want 10010", {alu_src_a, alu_src_b, alu_op});
                    end
                end
                go();
            end
        end
    endtask

    task automatic test_addi();
        state_t st[4];
        st = '{S_FETCH, S_DECODE, S_EXEC_I, S_ALU_WB};
        opcode = OP_IMM;
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            #1;
            nvec++;
            if (state !== st[k] || instr_retired !== (k == 3)) begin
                nerr++;
                $display("FAIL addi[%0d]: got state %0d ret %b want %0d %b",
                         k, state, instr_retired, st[k], k == 3);
            end
            if (k == 1 || k == 2) begin
                nvec++;
                if ({alu_src_a, alu_src_b, alu_op} !== ((k == 1) ? 5'b0_10_00 : 5'b1_10_11)) begin
                    nerr++;
                    $display("FAIL addi_sel[%0d]: got %b want %b", k, {alu_src_a, alu_src_b, alu_op},
                             (k == 1) ? 5'b0_10_00 : 5'b1_10_11);
                end
            end
            go();
        end
    endtask

    task automatic test_ld_stall();
        state_t st[9];
        logic   mr[9];
        st = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_LD_WB};
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_LOAD;
        for (int k = 0; k < 9; k++) begin
            mem_ready = mr[k];
            #1;
            nvec++;
            if (state !== st[k] || i_or_d !== (st[k] == S_MEM_RD)
                || mem_read !== (st[k] == S_FETCH || st[k] == S_MEM_RD) || mem_write !== 1'b0) begin
                nerr++;
                $display("FAIL ld[%0d]: got state %0d iord %b rd %b wr %b",
                         k, state, i_or_d, mem_read, mem_write);
            end
            nvec++;
            if ({reg_write, mem_to_reg, instr_retired} !== ((k == 8) ? 3'b111 : 3'b000)) begin
                nerr++;
                $display("FAIL ld_wb[%0d]: got %b want %b", k, {reg_write, mem_to_reg, instr_retired},
                         (k == 8) ? 3'b111 : 3'b000);
            end
            go();
        end
        nvec++;
        if (state !== S_FETCH) begin
            nerr++;
            $display("FAIL ld_len: got state %0d want 0 after 9 cycles", state);
        end
    endtask

    task automatic test_beq(input logic az);
        state_t st[3];
        st = '{S_FETCH, S_DECODE, S_BRANCH};
        opcode = OP_BRANCH;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b1;
            alu_zero = az;
            #1;
            nvec++;
            if (state !== st[k] || instr_retired !== (k == 2)) begin
                nerr++;
                $display("FAIL beq%0d[%0d]: got state %0d ret %b", az, k, state, instr_retired);
            end
            if (k == 2) begin
                nvec++;
                if ({pc_write, pc_src, alu_src_a, alu_src_b, alu_op} !== {az, az, 5'b1_00_01}) begin
                    nerr++;
                    $display("FAIL beq%0d_branch: got %b want %b", az,
                             {pc_write, pc_src, alu_src_a, alu_src_b, alu_op}, {az, az, 5'b1_00_01});
                end
            end
            go();
        end
        alu_zero = 1'b0;
        nvec++;
        if (state !== S_FETCH) begin
            nerr++;
            $display("FAIL beq%0d_len: got state %0d want 0", az, state);
        end
    endtask

    task automatic test_sd_stall();
        state_t st[7];
        logic   mr[7];
        st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR, S_MEM_WR, S_MEM_WR};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_STORE;
        for (int k = 0; k < 7; k++) begin
            mem_ready = mr[k];
            #1;
            nvec++;
            if (state !== st[k] || mem_write !== (k >= 3) || mem_read !== (k == 0)
                || reg_write !== 1'b0 || instr_retired !== (k == 6)) begin
                nerr++;
                $display("FAIL sd[%0d]: got state %0d wr %b rd %b rw %b ret %b", k, state,
                         mem_write, mem_read, reg_write, instr_retired);
            end
            go();
        end
    endtask

    task automatic test_timeout();
        // Stalled store: five stall cycles in MEM_WR, then TRAP.
        opcode = OP_STORE;
        for (int k = 0; k < 8; k++) begin
            mem_ready = (k < 3);
            #1;
            if (k == 7) begin
                nvec++;
                if (state !== S_MEM_WR || mem_write !== 1'b1 || instr_retired !== 1'b0) begin
                    nerr++;
                    $display("FAIL timeout_last_wait: got state %0d wr %b ret %b want 5 1 0",
                             state, mem_write, instr_retired);
                end
            end
            go();
        end
        nvec++;
        if (state !== S_TRAP || trap !== 1'b1 || mem_write !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_trap: got state %0d trap %b wr %b want 10 1 0", state, trap, mem_write);
        end
        reset = 1'b1;
        go();
        reset = 1'b0;
        // Same store, but mem_ready rises in the compare cycle.
        for (int k = 0; k < 8; k++) begin
            mem_ready = (k < 3) || (k == 7);
            #1;
            if (k == 7) begin
                nvec++;
                if (state !== S_MEM_WR || instr_retired !== 1'b1) begin
                    nerr++;
                    $display("FAIL timeout_race: got state %0d ret %b want 5 1", state, instr_retired);
                end
            end
            go();
        end
        nvec++;
        if (state !== S_FETCH || trap !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_race_next: got state %0d trap %b want 0 0", state, trap);
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        go();
        go();
        for (int k = 0; k < 20; k++) begin
            #1;
            nvec++;
            if (state !== S_TRAP || trap !== 1'b1 || instr_retired !== 1'b0
                || {pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
                nerr++;
                $display("FAIL illegal[%0d]: got state %0d trap %b ret %b en %b", k, state, trap,
                         instr_retired, {pc_write, ir_write, mem_read, mem_write, reg_write});
            end
            go();
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (trap !== 1'b0 || state !== 4'd0 || mem_read !== 1'b0) begin
            nerr++;
            $display("FAIL illegal_reset_hold: got trap %b state %0d rd %b want 0 0 0", trap, state, mem_read);
        end
        go();
        reset = 1'b0;
        #1;
        nvec++;
        if (state !== S_FETCH || trap !== 1'b0 || mem_read !== 1'b1) begin
            nerr++;
            $display("FAIL illegal_reset_exit: got state %0d trap %b rd %b want 0 0 1", state, trap, mem_read);
        end
    endtask

    task automatic test_reset_mid_wait();
        opcode = OP_STORE;
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k < 3);
            go();
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (mem_write !== 1'b0 || state !== 4'd0) begin
            nerr++;
            $display("FAIL reset_mid_wait: got wr %b state %0d want 0 0", mem_write, state);
        end
        go();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        nvec++;
        if (state !== S_FETCH || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_wait_exit: got state %0d rd %b wr %b want 0 1 0",
                     state, mem_read, mem_write);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_ld_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_sd_stall();
        test_timeout();
        test_illegal();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
